data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Data-memory slave on the core's data-memory port, one level below the Memory stage.
- Accepts one load or store request at a time from the core.
- Inserts a programmable number of wait states.
- Performs byte-masked word writes or full-word reads.
- Returns a single-cycle DM_valid pulse that releases the core's load/store stall.
- Read data is always the raw 32-bit word; byte/half extraction and sign extension stay in the core.

Parameters:
DATA_WIDTH, 32, data word width
ADDRESS, 32, core address width
DEPTH, 1024, memory size in 32-bit words (power of two)
LATENCY, 2, cycles from request acceptance to DM_valid (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
data_mem_request  input  1  access request from core; held high until DM_valid
data_mem_we_re  input  1  1 = store, 0 = load
data_mem_mask  input  4  byte-lane enables for stores; bit i = byte i
DM_alu_res_out  input  ADDRESS  byte address; word index = addr[log2(DEPTH)+1:2]
DM_store_data_out  input  DATA_WIDTH  store data, lane-aligned
DM_load_data_in  output  DATA_WIDTH  read word returned to core
DM_valid  output  1  one-cycle completion pulse for load or store

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-low.
- Reset values: state=IDLE, DM_valid=0, DM_load_data_in=0, wait counter=0. Memory array is not cleared.
- State machine states, shared enum: IDLE, WAIT, RESP.
- IDLE:
  - request sampled high → capture addr word index, we_re, mask, store data.
  - counter loads LATENCY-1.
  - next state = RESP if LATENCY==1, else WAIT.
- WAIT: counter decrements each cycle; when counter==1 the next state is RESP.
- Commit point, on the edge entering RESP:
  - store: write enabled byte lanes only; disabled lanes keep their old value.
  - load: register the array word into DM_load_data_in.
- RESP: DM_valid=1 for exactly this one cycle; next state is always IDLE.
- Latency: DM_valid rises exactly LATENCY cycles after the accepting edge.
- DM_load_data_in holds its value until the next load commit. It is not cleared after RESP and not changed by stores.
- While state≠IDLE, request and all inputs are ignored. Input changes during WAIT have no effect; captured values are used.
- Back-to-back: request high in the IDLE cycle after RESP is a new access. Minimum spacing between DM_valid pulses is LATENCY+1 cycles.
- Store with mask=4'b0000: no array change, DM_valid still pulses.
- Loads ignore mask.
- Address bits [1:0] are ignored.
- Address above DEPTH*4: wraps modulo DEPTH (upper bits dropped).
- Reset asserted mid-access (WAIT or RESP): abort immediately, no write committed, DM_valid=0.
- Read-after-write to the same word on consecutive accesses returns the new data.

Optional Feature:
Macro: DMEM_RANGE_ERR_EN
- Defined:
  - adds output DM_error (1 bit, reset 0), asserted together with DM_valid.
  - captured address ≥ DEPTH*4 → store suppressed, load returns 32'h0, DM_error=1.
  - in-range accesses → DM_error=0.
- Undefined: no DM_error port; out-of-range addresses wrap as described above.

Decomposition:
- Package dmem_pkg:
  - state enum typedef: IDLE, WAIT, RESP.
  - constants DMEM_READ=1'b0, DMEM_WRITE=1'b1.
  - function for word-index width, log2(DEPTH).
- Sub-module dmem_sram_array:
  - synchronous DEPTH×32 byte-enabled storage.
  - ports: clk, we, be[3:0], widx, wdata, rdata.
  - no reset.
  - data_mem_ctrl instantiates it and owns only the FSM, counter and capture registers.

Test Plan:
- Store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, mask 4'hF → DM_valid 2 cycles after accept. Load addr 0x10 → DM_load_data_in=0xDEADBEEF with DM_valid.
- Byte-masked store: preload 0x11223344 at 0x20; store 0xAABBCCDD, mask 4'b0101 → load returns 0x11BB33DD.
- Latency sweep LATENCY=1,3,7: accept edge to DM_valid = 1/3/7 cycles. DM_valid exactly 1 cycle wide. Back-to-back requests spaced LATENCY+1.
- Input change during WAIT: change addr and data after accept → original captured values are written. Mask 0 store → word unchanged, DM_valid still pulses.
- Reset mid-store in WAIT → DM_valid=0, state IDLE, later load of that address returns the prior value.
- Out-of-range, DEPTH=1024, store to 0x1004:
  - macro off → aliases word 1 (load 0x4 sees the data).
  - macro on → DM_error=1, no write, load of 0x1004 returns 0 with DM_error=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory slave: FSM state encoding,
// access direction codes and the word-index width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic DMEM_READ  = 1'b0;
  localparam logic DMEM_WRITE = 1'b1;

  function automatic int dmem_idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// DEPTH x 32 storage with per-byte write enables, synchronous write and
// combinational read of the addressed word. Contents are not reset.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = dmem_idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[widx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: one load/store at a time, LATENCY-cycle response with a
// one-cycle DM_valid pulse. Optional range checking under DMEM_RANGE_ERR_EN.
//
// state | meaning
// IDLE  | waiting for a request; captures the access when request is high
// WAIT  | counting wait states down; array committed on the edge into RESP
// RESP  | DM_valid high for this single cycle, then back to IDLE
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_mem_request,
  input  logic                  data_mem_we_re,
  input  logic [3:0]            data_mem_mask,
  input  logic [ADDRESS-1:0]    DM_alu_res_out,
  input  logic [DATA_WIDTH-1:0] DM_store_data_out,
  output logic [DATA_WIDTH-1:0] DM_load_data_in,
  output logic                  DM_valid
`ifdef DMEM_RANGE_ERR_EN
  ,
  output logic                  DM_error
`endif
);

  localparam int         AW     = dmem_idx_width(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit;

  logic [AW-1:0]         cap_idx;
  logic                  cap_we;
  logic [3:0]            cap_mask;
  logic [DATA_WIDTH-1:0] cap_data;

  logic [AW-1:0]         sel_idx;
  logic                  sel_we;
  logic [3:0]            sel_mask;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_oor;

  logic                  sram_we;
  logic [31:0]           sram_rdata;

`ifdef DMEM_RANGE_ERR_EN
  logic in_oor, cap_oor;
  logic unused_addr;
  assign in_oor      = |DM_alu_res_out[ADDRESS-1:AW+2];
  assign unused_addr = ^DM_alu_res_out[1:0];
`else
  logic unused_addr;
  assign unused_addr = ^{DM_alu_res_out[ADDRESS-1:AW+2], DM_alu_res_out[1:0]};
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (data_mem_request) begin
          accept  = 1'b1;
          cnt_nxt = LAT_M1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is also the capture edge, so the live inputs are used.
  always_comb begin
    if (state == IDLE) begin
      sel_idx  = DM_alu_res_out[AW+1:2];
      sel_we   = data_mem_we_re;
      sel_mask = data_mem_mask;
      sel_data = DM_store_data_out;
`ifdef DMEM_RANGE_ERR_EN
      sel_oor  = in_oor;
`else
      sel_oor  = 1'b0;
`endif
    end else begin
      sel_idx  = cap_idx;
      sel_we   = cap_we;
      sel_mask = cap_mask;
      sel_data = cap_data;
`ifdef DMEM_RANGE_ERR_EN
      sel_oor  = cap_oor;
`else
      sel_oor  = 1'b0;
`endif
    end
  end

  // Reset is folded in so nothing is written to the unreset array while rst is low.
  assign sram_we = rst & commit & (sel_we == DMEM_WRITE) & ~sel_oor;

  dmem_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .be    (sel_mask),
    .widx  (sel_idx),
    .wdata (sel_data[31:0]),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      DM_valid        <= 1'b0;
      DM_load_data_in <= '0;
      cap_idx         <= '0;
      cap_we          <= DMEM_READ;
      cap_mask        <= 4'd0;
      cap_data        <= '0;
`ifdef DMEM_RANGE_ERR_EN
      cap_oor         <= 1'b0;
      DM_error        <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      DM_valid <= commit;
      if (accept) begin
        cap_idx  <= DM_alu_res_out[AW+1:2];
        cap_we   <= data_mem_we_re;
        cap_mask <= data_mem_mask;
        cap_data <= DM_store_data_out;
`ifdef DMEM_RANGE_ERR_EN
        cap_oor  <= in_oor;
`endif
      end
      if (commit && (sel_we == DMEM_READ)) begin
        DM_load_data_in <= sel_oor ? '0 : DATA_WIDTH'(sram_rdata);
      end
`ifdef DMEM_RANGE_ERR_EN
      DM_error <= commit & sel_oor;
`endif
    end
  end

endmodule
